// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU issue slice.
//   ALU_WIDTH / ALU_FUNC_WIDTH : operand and function-code widths
//   aluf_t                     : ALU function codes (0..22 legal)
//   state_t                    : issue FSM states
//   func_legal()               : true for codes the ALU understands
package alu_pkg;

    localparam int ALU_WIDTH      = 32;
    localparam int ALU_FUNC_WIDTH = 5;
    localparam int NUM_FUNCS      = 23;

    typedef enum logic [ALU_FUNC_WIDTH-1:0] {
        F_NOOP  = 5'd0,
        F_ADD   = 5'd1,
        F_SUB   = 5'd2,
        F_RSUB  = 5'd3,
        F_AND   = 5'd4,
        F_XOR   = 5'd5,
        F_OR    = 5'd6,
        F_NOR   = 5'd7,
        F_XNOR  = 5'd8,
        F_ANDN  = 5'd9,
        F_SHL   = 5'd10,
        F_SHR   = 5'd11,
        F_SRA   = 5'd12,
        F_ROL   = 5'd13,
        F_ROR   = 5'd14,
        F_MIN   = 5'd15,
        F_MAX   = 5'd16,
        F_PASSB = 5'd17,
        F_INC   = 5'd18,
        F_DEC   = 5'd19,
        F_SLT   = 5'd20,
        F_SLTU  = 5'd21,
        F_SEQ   = 5'd22
    } aluf_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic func_legal(input logic [ALU_FUNC_WIDTH-1:0] f);
        return f < 5'(NUM_FUNCS);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile -- architectural register array.
//   clk, rst_n        : clock, async active-low reset (clears every register)
//   ra_addr / ra_data : async read port A
//   rb_addr / rb_data : async read port B
//   we, wa, wd        : synchronous write port; writes to r0 are dropped
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [NREGS-1:0][WIDTH-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // r0 is never written, but decode it explicitly so it reads zero
    // regardless of what the array holds.
    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- issues one command at a time to an external combinational ALU
// and writes the result back to the register file.
//   clk, rst_n                     : clock, async active-low reset
//   cmd_valid/cmd_ready            : command handshake (ready only in IDLE)
//   cmd_func, cmd_rd, cmd_rs1/rs2  : function code and register indices
//   cmd_use_imm/cmd_imm            : immediate replaces rs2 as operand b
//   cmd_use_carry                  : carry flag feeds alu_ci
//   alu_a/alu_b/alu_ci/alu_f       : registered ALU drive, held between ops
//   alu_s/alu_co                   : ALU result, captured at end of EXEC
//   res_valid/res_ready            : result handshake; writeback on accept
//   res_data/res_co/res_rd         : result payload
//   err                            : one-cycle pulse on an illegal function
module alu_issue #(
    parameter int NREGS     = 8,
    parameter int ALU_WIDTH = alu_pkg::ALU_WIDTH,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [alu_pkg::ALU_FUNC_WIDTH-1:0] cmd_func,
    input  logic [AW-1:0]                      cmd_rd,
    input  logic [AW-1:0]                      cmd_rs1,
    input  logic [AW-1:0]                      cmd_rs2,
    input  logic                               cmd_use_imm,
    input  logic [ALU_WIDTH-1:0]               cmd_imm,
    input  logic                               cmd_use_carry,
    output logic [ALU_WIDTH-1:0]               alu_a,
    output logic [ALU_WIDTH-1:0]               alu_b,
    output logic                               alu_ci,
    output logic [alu_pkg::ALU_FUNC_WIDTH-1:0] alu_f,
    input  logic [ALU_WIDTH-1:0]               alu_s,
    input  logic                               alu_co,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [ALU_WIDTH-1:0]               res_data,
    output logic                               res_co,
    output logic [AW-1:0]                      res_rd,
    output logic                               err
);

    import alu_pkg::*;

    state_t                    state;
    logic                      carry;
    logic                      is_addsub;
    logic [ALU_WIDTH-1:0]      rs1_data;
    logic [ALU_WIDTH-1:0]      rs2_data;
    logic [ALU_FUNC_WIDTH-1:0] nxt_f;
    logic [ALU_WIDTH-1:0]      nxt_b;
    logic                      nxt_ci;
    logic                      accept;
    logic                      wb;

    assign accept = cmd_valid && cmd_ready;
    assign wb     = res_valid && res_ready;

    alu_regfile #(
        .NREGS (NREGS),
        .WIDTH (ALU_WIDTH)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (cmd_rs1),
        .ra_data (rs1_data),
        .rb_addr (cmd_rs2),
        .rb_data (rs2_data),
        .we      (wb),
        .wa      (res_rd),
        .wd      (res_data)
    );

    // Operand/function remapping. INC/DEC ride on ADD/SUB with a forced
    // b=1 and ci=0 so they never pick up a stale carry; NOOP becomes OR
    // with zero so the ALU simply passes rs1 through.
    always_comb begin
        nxt_f  = cmd_func;
        nxt_b  = cmd_use_imm ? cmd_imm : rs2_data;
        nxt_ci = cmd_use_carry ? carry : 1'b0;
        case (cmd_func)
            F_NOOP: begin
                nxt_f = F_OR;
                nxt_b = '0;
            end
            F_INC: begin
                nxt_f  = F_ADD;
                nxt_b  = ALU_WIDTH'(1);
                nxt_ci = 1'b0;
            end
            F_DEC: begin
                nxt_f  = F_SUB;
                nxt_b  = ALU_WIDTH'(1);
                nxt_ci = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_co    <= 1'b0;
            res_rd    <= '0;
            err       <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ci    <= 1'b0;
            alu_f     <= '0;
            carry     <= 1'b0;
            is_addsub <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (func_legal(cmd_func)) begin
                            // Sources are sampled here, so rd==rs1/rs2
                            // sees the value from before this op's write.
                            alu_a     <= rs1_data;
                            alu_b     <= nxt_b;
                            alu_ci    <= nxt_ci;
                            alu_f     <= nxt_f;
                            res_rd    <= cmd_rd;
                            is_addsub <= (cmd_func == F_ADD) || (cmd_func == F_SUB);
                            cmd_ready <= 1'b0;
                            state     <= ST_EXEC;
                        end else begin
                            // Illegal op: stay ready, touch no state.
                            err <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    res_data  <= alu_s;
                    res_co    <= alu_co;
                    res_valid <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    if (res_ready) begin
                        // Carry tracks only true ADD/SUB, not INC/DEC.
                        if (is_addsub) carry <= res_co;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_func = '0;
    logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic        cmd_use_imm = 1'b0;
    logic [31:0] cmd_imm = '0;
    logic        cmd_use_carry = 1'b0;
    logic [31:0] alu_a, alu_b, alu_s;
    logic        alu_ci, alu_co;
    logic [4:0]  alu_f;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_co;
    logic [2:0]  res_rd;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers and carry flag.
    logic [31:0] mreg [8];
    logic        mcarry;
    logic [31:0] last_data;
    logic [4:0]  last_f;
    logic [31:0] last_b;

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_rd        (cmd_rd),
        .cmd_rs1       (cmd_rs1),
        .cmd_rs2       (cmd_rs2),
        .cmd_use_imm   (cmd_use_imm),
        .cmd_imm       (cmd_imm),
        .cmd_use_carry (cmd_use_carry),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ci        (alu_ci),
        .alu_f         (alu_f),
        .alu_s         (alu_s),
        .alu_co        (alu_co),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_co        (res_co),
        .res_rd        (res_rd),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Downstream ALU: combinational, defined by this bench.
    always_comb begin
        alu_s  = '0;
        alu_co = 1'b0;
        case (alu_f)
            5'd1:    {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
            5'd2:    {alu_co, alu_s} = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_ci};
            5'd4:    alu_s = alu_a & alu_b;
            5'd5:    alu_s = alu_a ^ alu_b;
            5'd6:    alu_s = alu_a | alu_b;
            default: alu_s = ~(alu_a ^ alu_b);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural meaning of each command, by original function code.
    function automatic logic [32:0] ref_exec(input int func, input logic [31:0] a,
                                             input logic [31:0] b, input logic ci);
        longint s;
        case (func)
            0:  return {1'b0, a};
            1: begin
                s = longint'(a) + longint'(b) + longint'(ci);
                return {s > 64'hFFFF_FFFF, s[31:0]};
            end
            2:  return {longint'(a) < longint'(b) + longint'(ci), a - b - 32'(ci)};
            4:  return {1'b0, a & b};
            5:  return {1'b0, a ^ b};
            6:  return {1'b0, a | b};
            18: return {a == 32'hFFFF_FFFF, a + 32'd1};
            19: return {a == 32'd0, a - 32'd1};
            default: return {1'b0, ~(a ^ b)};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mcarry = 1'b0;
    endtask

    // Issue one command, follow it through, and update the model on writeback.
    // Entered and left at #1 after a rising edge.
    task automatic do_cmd(input int func, input int rd, input int rs1, input int rs2,
                          input bit use_imm, input logic [31:0] imm,
                          input bit use_carry, input int dly);
        logic [31:0] a, braw, eb;
        logic        ciraw, eci;
        int          ef, n;
        logic [32:0] r;
        a     = mreg[rs1];
        braw  = use_imm ? imm : mreg[rs2];
        ciraw = use_carry ? mcarry : 1'b0;
        eb = braw; eci = ciraw; ef = func;
        if (func == 0)  begin ef = 6; eb = 32'd0; end
        if (func == 18) begin ef = 1; eb = 32'd1; eci = 1'b0; end
        if (func == 19) begin ef = 2; eb = 32'd1; eci = 1'b0; end
        r = ref_exec(func, a, braw, ciraw);

        cmd_func = 5'(func); cmd_rd = 3'(rd); cmd_rs1 = 3'(rs1); cmd_rs2 = 3'(rs2);
        cmd_use_imm = use_imm; cmd_imm = imm; cmd_use_carry = use_carry;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        if (func >= 23) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_valid", {31'd0, res_valid}, 32'd0);
            chk("err_ready", {31'd0, cmd_ready}, 32'd1);
            @(posedge clk); #1;
            chk("err_width", {31'd0, err}, 32'd0);
            return;
        end

        // EXEC
        chk("exec_f", {27'd0, alu_f}, 32'(ef));
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, eb);
        chk("exec_ci", {31'd0, alu_ci}, {31'd0, eci});
        chk("exec_valid", {31'd0, res_valid}, 32'd0);
        chk("exec_ready", {31'd0, cmd_ready}, 32'd0);
        last_f = alu_f; last_b = alu_b;
        @(posedge clk); #1;

        // WB
        chk("wb_valid", {31'd0, res_valid}, 32'd1);
        chk("wb_data", res_data, r[31:0]);
        chk("wb_co", {31'd0, res_co}, {31'd0, r[32]});
        chk("wb_rd", {29'd0, res_rd}, 32'(rd));
        chk("wb_err", {31'd0, err}, 32'd0);
        last_data = res_data;
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", res_data, r[31:0]);
            chk("hold_rd", {29'd0, res_rd}, 32'(rd));
            chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_valid", {31'd0, res_valid}, 32'd0);
        chk("post_ready", {31'd0, cmd_ready}, 32'd1);
        if (rd != 0) mreg[rd] = r[31:0];
        if (func == 1 || func == 2) mcarry = r[32];
    endtask

    // Read a register back through a NOOP and compare with a known value.
    task automatic read_reg(input string tag, input int rs, input logic [31:0] exp);
        do_cmd(0, 0, rs, 0, 1'b0, 32'd0, 1'b0, 0);
        chk(tag, last_data, exp);
    endtask

    initial begin
        model_reset();
        last_data = '0; last_f = '0; last_b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_f", {27'd0, alu_f}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic ADD: R1=5, R2=7, R3=R1+R2
        do_cmd(1, 1, 0, 0, 1'b1, 32'd5, 1'b0, 0);
        do_cmd(1, 2, 0, 0, 1'b1, 32'd7, 1'b0, 0);
        do_cmd(1, 3, 1, 2, 1'b0, 32'd0, 1'b0, 0);
        chk("add_f", {27'd0, last_f}, 32'd1);
        chk("add_12", last_data, 32'd12);
        read_reg("r3_12", 3, 32'd12);

        // Wrap-around carry, then carry-in
        do_cmd(1, 1, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        do_cmd(1, 2, 1, 0, 1'b1, 32'd1, 1'b0, 0);
        chk("wrap_0", last_data, 32'd0);
        do_cmd(1, 5, 0, 0, 1'b0, 32'd0, 1'b1, 0);
        chk("carry_in", last_data, 32'd1);

        // Backpressure for 5 cycles, then confirm writeback landed
        do_cmd(5, 6, 1, 3, 1'b0, 32'd0, 1'b0, 5);
        read_reg("bp_wb", 6, 32'hFFFF_FFFF ^ 32'd12);

        // Illegal function leaves state untouched
        do_cmd(25, 3, 1, 2, 1'b0, 32'd0, 1'b0, 0);
        read_reg("ill_r3", 3, 32'd12);

        // INC / DEC, write to r0 ignored
        do_cmd(1, 4, 0, 0, 1'b1, 32'd9, 1'b0, 0);
        do_cmd(18, 6, 4, 0, 1'b0, 32'd0, 1'b1, 0);
        chk("inc_f", {27'd0, last_f}, 32'd1);
        chk("inc_b", last_b, 32'd1);
        chk("inc_10", last_data, 32'd10);
        do_cmd(19, 0, 0, 0, 1'b0, 32'd0, 1'b1, 0);
        chk("dec_ff", last_data, 32'hFFFF_FFFF);
        read_reg("r0_zero", 0, 32'd0);

        // rd == rs1 uses the pre-write value
        do_cmd(1, 4, 4, 4, 1'b0, 32'd0, 1'b0, 1);
        read_reg("self_add", 4, 32'd18);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            do_cmd(int'($urandom_range(0, 26)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 8; i++) read_reg("rand_reg", i, mreg[i]);

        // Reset during WB discards the in-flight result
        do_cmd(1, 7, 0, 0, 1'b1, 32'd33, 1'b0, 0);
        cmd_func = 5'd1; cmd_rd = 3'd7; cmd_rs1 = 3'd7; cmd_use_imm = 1'b1;
        cmd_imm = 32'd1; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_wb_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_data", res_data, 32'd0);
        chk("mid_rst_f", {27'd0, alu_f}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
        read_reg("mid_r7", 7, 32'd0);
        do_cmd(1, 2, 0, 0, 1'b0, 32'd0, 1'b1, 0);
        chk("mid_carry", last_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
